lift_result_writer: RTL

Downstream stage of the lift datapath: consumes the stream of reduced residues leaving the final modular subtraction and writes each residue into the RNS residue memory, one write per cycle. Residues arrive in groups of 7, one per target modulus, for every coefficient of a polynomial. The block tracks residue and coefficient position and produces bank/address write commands. It range-checks every residue against its modulus and signals completion of the polynomial.

---
 rtl/lift_result_writer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lift_result_writer.sv
// rtl/lift_result_writer.sv - writes reduced RNS residues into residue memory, 7 per coefficient
module lift_result_writer #(
  parameter int COEFF_COUNT = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [29:0]       din,
  input  logic              din_we,
  output logic              wr_en,
  output logic [3:0]        wr_mod_idx,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [29:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic              seq_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_res_idx;
  logic [ADDR_W-1:0]   r_coeff_addr;
  logic [3:0]          r_base;
  logic                w_start_ok;
  logic                w_accept;
  logic                w_last;
  logic                w_over;
  logic [3:0]          w_mod_idx;

  function automatic logic [29:0] modulus(input logic [3:0] idx);
    case (idx)
      4'd0:    modulus = 30'd1068564481;
      4'd1:    modulus = 30'd1069219841;
      4'd2:    modulus = 30'd1070727169;
      4'd3:    modulus = 30'd1071513601;
      4'd4:    modulus = 30'd1072496641;
      4'd5:    modulus = 30'd1073479681;
      4'd6:    modulus = 30'd1068433409;
      4'd7:    modulus = 30'd1068236801;
      4'd8:    modulus = 30'd1065811969;
      4'd9:    modulus = 30'd1065484289;
      4'd10:   modulus = 30'd1064697857;
      4'd11:   modulus = 30'd1063452673;
      4'd12:   modulus = 30'd1063321601;
      default: modulus = '1;
    endcase
  endfunction

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_accept   = (r_state == RUN) && din_we;
  assign w_last     = (r_res_idx == 3'd6) && (r_coeff_addr == ADDR_W'(COEFF_COUNT - 1));
  assign w_mod_idx  = {1'b0, r_res_idx} + r_base;
  assign w_over     = din >= modulus(w_mod_idx);
  assign busy       = (r_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_accept && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_idx    <= 3'd0;
      r_coeff_addr <= '0;
      r_base       <= 4'd0;
    end else if (w_start_ok) begin
      r_res_idx    <= 3'd0;
      r_coeff_addr <= '0;
      r_base       <= mode ? 4'd0 : 4'd6;
    end else if (w_accept) begin
      if (r_res_idx == 3'd6) begin
        r_res_idx    <= 3'd0;
        r_coeff_addr <= r_coeff_addr + ADDR_W'(1);
      end else begin
        r_res_idx    <= r_res_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_mod_idx <= 4'd0;
      wr_addr    <= '0;
      wr_data    <= 30'd0;
      done       <= 1'b0;
    end else begin
      wr_en <= w_accept;
      done  <= w_accept && w_last;
      if (w_accept) begin
        wr_mod_idx <= w_mod_idx;
        wr_addr    <= r_coeff_addr;
        wr_data    <= din;
      end
    end
  end

  // A stray residue in the start cycle is still a sequencing error, so the set wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      if (w_start_ok)             range_err <= 1'b0;
      else if (w_accept && w_over) range_err <= 1'b1;
      if ((r_state == IDLE) && din_we) seq_err <= 1'b1;
      else if (w_start_ok)             seq_err <= 1'b0;
    end
  end

endmodule
